dmem_responder: RTL and testbench

- Handshaked data-memory target serving load/store requests from the core's data port.
- Replaces the zero-latency combinational data memory when a multi-cycle or stallable memory is modelled.
- Accepts one request at a time, inserts LATENCY wait cycles, then holds a response until the core takes it.

---
 rtl/dmem_pkg.sv | 16 +
 rtl/dmem_responder_if.sv | 26 ++
 rtl/dmem_array.sv | 29 ++
 rtl/dmem_responder.sv | 111 +++++++++++
 tb/tb_dmem_responder.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the handshaked data-memory responder.
package dmem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} dmem_state_t;

  // Full-word access must be word aligned; half-word lanes must be half-word aligned.
  function automatic logic is_misaligned(logic [BE_W-1:0] be, logic [1:0] addr_lo);
    return ((be == 4'b1111) && (addr_lo != 2'b00)) ||
           (((be == 4'b0011) || (be == 4'b1100)) && addr_lo[0]);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the core data port (master) and the memory target (slave).
interface dmem_responder_if;
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_array.sv
// Byte-enabled word RAM: synchronous write, asynchronous read, contents never reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [ADDR_W-1:0] index,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [WORD_W-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem[index][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[index];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory target: one request in flight, LATENCY wait cycles, held response.
// Optional misalignment trap enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic            clk,
  input  logic            reset,
  dmem_responder_if.slave bus
);

  dmem_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q;
  logic [ADDR_W-1:0] idx_q;
  logic [WORD_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic [WORD_W-1:0] rdata_q;
  logic              err_q;
  logic              mis_q;
  logic              accept;
  logic              access;
  logic              mem_we;
  logic [WORD_W-1:0] mem_rdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    access  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          accept  = 1'b1;
          cnt_d   = CNT_W'(LATENCY);
          state_d = (LATENCY == 0) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ACCESS;
      end
      ACCESS: begin
        access  = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= bus.req_we;
        idx_q   <= bus.req_addr[ADDR_W+1:2];
        wdata_q <= bus.req_wdata;
        be_q    <= bus.req_be;
`ifdef DMEM_MISALIGN_TRAP_EN
        mis_q   <= is_misaligned(bus.req_be, bus.req_addr[1:0]);
`else
        mis_q   <= 1'b0;
`endif
      end
      if (access) begin
        // Stores and trapped requests return zero data.
        rdata_q <= (we_q || mis_q) ? '0 : mem_rdata;
        err_q   <= mis_q;
      end
    end
  end

  assign mem_we = access && we_q && !mis_q;

  dmem_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .be    (be_q),
    .index (idx_q),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
`ifdef DMEM_MISALIGN_TRAP_EN
  assign bus.rsp_err   = err_q;
`else
  assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a transaction-level reference model and per-cycle compare.
module tb_dmem_responder;

  localparam int unsigned AW  = 10;
  localparam int unsigned LAT = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if bus ();

  dmem_responder #(
    .ADDR_W  (AW),
    .LATENCY (LAT)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic bit model_mis(input logic [3:0] be, input logic [31:0] a);
`ifdef DMEM_MISALIGN_TRAP_EN
    if (be == 4'hf) return a[1:0] != 2'b00;
    if (be == 4'h3 || be == 4'hc) return a[0];
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: memory keyed by word index, one transaction tracked by cycle number.
  logic [31:0] mmem [int];
  bit          m_busy  = 0;
  bit          m_rsp   = 0;
  bit          m_known = 0;
  logic [31:0] m_rdata = '0;
  logic        m_err   = 1'b0;
  logic        m_we    = 1'b0;
  logic [31:0] m_addr  = '0;
  logic [31:0] m_wdata = '0;
  logic [3:0]  m_be    = '0;
  int          cyc     = 0;
  int          acc_cyc = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_busy  = 0;
      m_rsp   = 0;
      m_rdata = '0;
      m_err   = 1'b0;
    end else begin
      cyc++;
      if (m_rsp) begin
        if (bus.rsp_ready) begin
          m_rsp  = 0;
          m_busy = 0;
        end
      end else if (m_busy) begin
        if (cyc == acc_cyc) begin
          int idx;
          logic [31:0] w;
          idx     = int'(m_addr[AW+1:2]);
          m_rsp   = 1;
          m_known = 1;
          m_rdata = '0;
          m_err   = 1'b0;
          if (model_mis(m_be, m_addr)) begin
            m_err = 1'b1;
          end else if (m_we) begin
            w = mmem.exists(idx) ? mmem[idx] : 32'hxxxx_xxxx;
            for (int b = 0; b < 4; b++) if (m_be[b]) w[8*b +: 8] = m_wdata[8*b +: 8];
            mmem[idx] = w;
          end else if (mmem.exists(idx)) begin
            m_rdata = mmem[idx];
            m_known = (^m_rdata !== 1'bx);
          end else begin
            m_known = 0;
          end
        end
      end else if (bus.req_valid) begin
        m_busy  = 1;
        m_we    = bus.req_we;
        m_addr  = bus.req_addr;
        m_wdata = bus.req_wdata;
        m_be    = bus.req_be;
        acc_cyc = cyc + LAT + 1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("req_ready", 32'(bus.req_ready), 32'(!m_busy));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_rsp));
    if (m_rsp) chk("rsp_err", 32'(bus.rsp_err), 32'(m_err));
    if (m_rsp && m_known) chk("rsp_rdata", bus.rsp_rdata, m_rdata);
    if (!rst_n) begin
      chk("rst_rdata", bus.rsp_rdata, 32'h0);
      chk("rst_err", 32'(bus.rsp_err), 32'h0);
    end
  end

  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input int hold,
                     output logic [31:0] rdata, output logic err, output int lat);
    @(posedge clk); #2;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    @(posedge clk); #2;
    // Scramble inputs after acceptance; the target must use its latched copy.
    bus.req_valid = 1'b0;
    bus.req_we    = ~we;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    bus.req_be    = 4'($urandom);
    lat = 0;
    while (!bus.rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 40) chk("rsp_timeout", 32'(lat), 32'(LAT + 1));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(bus.rsp_valid), 32'h1);
      chk("hold_req_ready", 32'(bus.req_ready), 32'h0);
    end
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    #1 bus.rsp_ready = 1'b1;
    @(posedge clk); #2;
    bus.rsp_ready = 1'b0;
    chk("ready_after_rsp", 32'(bus.req_ready), 32'h1);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lt;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_req_ready", 32'(bus.req_ready), 32'h1);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 32'h0);

    txn(1'b1, 32'h40, 32'hDEADBEEF, 4'hf, 0, rd, er, lt);
    chk("store_latency", 32'(lt), 32'd3);
    chk("store_rdata", rd, 32'h0);
    chk("store_err", 32'(er), 32'h0);
    txn(1'b0, 32'h40, 32'h0, 4'h0, 0, rd, er, lt);
    chk("load_deadbeef", rd, 32'hDEADBEEF);
    chk("load_latency", 32'(lt), 32'd3);

    txn(1'b1, 32'h40, 32'h000000AA, 4'h1, 0, rd, er, lt);
    txn(1'b1, 32'h40, 32'hFFFFFFFF, 4'h0, 0, rd, er, lt);
    txn(1'b0, 32'h40, 32'h0, 4'h0, 0, rd, er, lt);
    chk("byte_lane", rd, 32'hDEADBEAA);

    // rsp_ready while idle must be ignored.
    @(posedge clk); #2 bus.rsp_ready = 1'b1;
    @(posedge clk); #2 bus.rsp_ready = 1'b0;

    txn(1'b0, 32'h40, 32'h0, 4'h0, 5, rd, er, lt);
    chk("backpressure_rdata", rd, 32'hDEADBEAA);

    txn(1'b1, 32'h1040, 32'h12345678, 4'hf, 0, rd, er, lt);
    txn(1'b0, 32'h0040, 32'h0, 4'h0, 0, rd, er, lt);
    chk("wrap_load", rd, 32'h12345678);

    txn(1'b1, 32'h80, 32'h11223344, 4'hf, 0, rd, er, lt);
    @(posedge clk); #2;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h80;
    bus.req_wdata = 32'hFFFFFFFF;
    bus.req_be    = 4'hf;
    @(posedge clk); #2;
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abandoned_no_rsp", 32'(bus.rsp_valid), 32'h0);
    end
    txn(1'b0, 32'h80, 32'h0, 4'h0, 0, rd, er, lt);
    chk("abandoned_store", rd, 32'h11223344);

    txn(1'b0, 32'h42, 32'h0, 4'hf, 0, rd, er, lt);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("misalign_err", 32'(er), 32'h1);
    chk("misalign_rdata", rd, 32'h0);
    txn(1'b1, 32'h42, 32'hCAFEF00D, 4'hf, 0, rd, er, lt);
    chk("misalign_store_err", 32'(er), 32'h1);
    txn(1'b0, 32'h40, 32'h0, 4'hf, 0, rd, er, lt);
    chk("misalign_untouched", rd, 32'h12345678);
`else
    chk("misalign_err", 32'(er), 32'h0);
    chk("misalign_rdata", rd, 32'h12345678);
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
